// File: rtl/monsopc_pio_pkg.sv
// Shared constants and helpers for the SOPC input PIO.
// Register offsets, edge/irq mode selectors and a width helper.
package monsopc_pio_pkg;

    typedef logic [1:0] pio_addr_t;

    localparam pio_addr_t ADDR_DATA    = 2'd0;
    localparam pio_addr_t ADDR_RSVD    = 2'd1;
    localparam pio_addr_t ADDR_IRQMASK = 2'd2;
    localparam pio_addr_t ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

    function automatic int clog2(input int v);
        int r;
        for (r = 0; (1 << r) < v; r++) begin
        end
        return r;
    endfunction

endpackage

// File: rtl/monsopc_pio_debounce.sv
// One input channel: synchroniser chain followed by a mismatch-count debouncer.
// chg is high in the cycle whose edge will flip stable to the synchronised level.
module monsopc_pio_debounce
    import monsopc_pio_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic stable,
    output logic chg
);

    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];
    assign chg  = (sync != stable) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == stable) begin
                cnt <= '0;
            end else if (chg) begin
                stable <= sync;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/monsopc_pio_in_irq.sv
// Avalon-MM input PIO: debounced inputs, edge capture, irq mask and one irq line.
// Offset 0 stays compatible with the old read-only button port.
module monsopc_pio_in_irq
    import monsopc_pio_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0,
    parameter int IRQ_MODE        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] chg;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             wr;
    logic             irq_src;
    logic             unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_ch
        monsopc_pio_debounce #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .reset (reset),
            .raw   (in_port[g]),
            .stable(stable[g]),
            .chg   (chg[g])
        );
    end

    // chg means stable is about to invert, so the new level is ~stable
    assign rise = chg & ~stable;
    assign fall = chg & stable;
    assign evt  = (EDGE_TYPE == EDGE_FALL) ? fall :
                  (EDGE_TYPE == EDGE_ANY)  ? (rise | fall) : rise;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign clr          = (wr && address == ADDR_EDGECAP) ? wdata : '0;

    assign irq_src = (IRQ_MODE == IRQ_LEVEL) ? |(stable & irqmask)
                                             : |(edgecap & irqmask);

    always_comb begin
        rd_mux = '0;
        unique case (address)
            ADDR_DATA:    rd_mux = 32'(stable);
            ADDR_IRQMASK: rd_mux = 32'(irqmask);
            ADDR_EDGECAP: rd_mux = 32'(edgecap);
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irqmask  <= '0;
            edgecap  <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            if (wr && address == ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
            edgecap  <= (edgecap & ~clr) | evt;
            readdata <= rd_mux;
            irq      <= irq_src;
        end
    end

endmodule

// File: tb/tb_monsopc_pio_in_irq.sv
// Directed bench: six configurations share one bus, each with its own inputs.
// Expected values are hand-derived from the documented latencies.
module tb_monsopc_pio_in_irq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;

    logic [1:0]  in_e0 = '0, in_fall = '0, in_any = '0, in_lvl = '0;
    logic [31:0] in_w32 = '0;
    logic [0:0]  in_w1 = '0;

    logic [31:0] rd_e0, rd_fall, rd_any, rd_lvl, rd_w32, rd_w1;
    logic        irq_e0, irq_fall, irq_any, irq_lvl, irq_w32, irq_w1;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    monsopc_pio_in_irq u_e0 (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_e0),
        .in_port(in_e0), .irq(irq_e0)
    );

    monsopc_pio_in_irq #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_fall),
        .in_port(in_fall), .irq(irq_fall)
    );

    monsopc_pio_in_irq #(.DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_any),
        .in_port(in_any), .irq(irq_any)
    );

    monsopc_pio_in_irq #(.DEBOUNCE_CYCLES(4), .IRQ_MODE(0)) u_lvl (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_lvl),
        .in_port(in_lvl), .irq(irq_lvl)
    );

    monsopc_pio_in_irq #(.WIDTH(32), .DEBOUNCE_CYCLES(4)) u_w32 (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_w32),
        .in_port(in_w32), .irq(irq_w32)
    );

    monsopc_pio_in_irq #(.WIDTH(1), .DEBOUNCE_CYCLES(4)) u_w1 (
        .clk(clk), .reset(reset), .address(address),
        .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rd_w1),
        .in_port(in_w1), .irq(irq_w1)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        address = a;
        tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        chk("rst_readdata", rd_e0, 32'h0);
        chk("rst_irq", {31'd0, irq_e0}, 32'h0);
        rd(2'd2); chk("rst_irqmask", rd_e0, 32'h0);
        rd(2'd3); chk("rst_edgecap", rd_e0, 32'h0);
        rd(2'd1); chk("rsvd_read", rd_e0, 32'h0);
        rd(2'd0); chk("data_low", rd_e0, 32'h0);

        in_e0 = 2'b01;
        tick(10);
        in_e0 = 2'b00;
        tick(6);
        rd(2'd0); chk("glitch_data", rd_e0, 32'h0);
        rd(2'd3); chk("glitch_edgecap", rd_e0, 32'h0);

        address = 2'd0;
        in_e0 = 2'b01;
        tick(18); chk("data_edge18_pre", rd_e0, 32'h0);
        tick();   chk("data_edge18_post", rd_e0, 32'h1);
        rd(2'd3); chk("edgecap_rise", rd_e0, 32'h1);
        chk("irq_unmasked", {31'd0, irq_e0}, 32'h0);

        wr(2'd2, 32'h1);
        chk("irq_mask_edge", {31'd0, irq_e0}, 32'h0);
        tick();
        chk("irq_mask_next", {31'd0, irq_e0}, 32'h1);
        wr(2'd3, 32'h1);
        chk("irq_clr_edge", {31'd0, irq_e0}, 32'h1);
        rd(2'd3);
        chk("edgecap_cleared", rd_e0, 32'h0);
        chk("irq_clr_next", {31'd0, irq_e0}, 32'h0);

        in_e0 = 2'b11;
        tick(17);
        wr(2'd3, 32'h2);
        rd(2'd3); chk("race_set_wins", rd_e0, 32'h2);
        chk("race_irq_unmasked", {31'd0, irq_e0}, 32'h0);
        wr(2'd3, 32'h2);
        rd(2'd3); chk("w1c_bit1", rd_e0, 32'h0);

        in_fall = 2'b01;
        in_any  = 2'b01;
        tick(8);
        rd(2'd3);
        chk("fall_no_rise", rd_fall, 32'h0);
        chk("any_rise", rd_any, 32'h1);
        rd(2'd0);
        chk("fall_data", rd_fall, 32'h1);
        wr(2'd3, 32'h1);
        in_fall = 2'b00;
        in_any  = 2'b00;
        tick(8);
        rd(2'd3);
        chk("fall_capture", rd_fall, 32'h1);
        chk("any_fall", rd_any, 32'h1);
        chk("fall_irq", {31'd0, irq_fall}, 32'h1);

        wr(2'd2, 32'h2);
        in_lvl = 2'b10;
        tick(6);
        chk("lvl_irq_pre", {31'd0, irq_lvl}, 32'h0);
        tick();
        chk("lvl_irq_rise", {31'd0, irq_lvl}, 32'h1);
        in_lvl = 2'b00;
        tick(6);
        chk("lvl_irq_hold", {31'd0, irq_lvl}, 32'h1);
        tick();
        chk("lvl_irq_fall", {31'd0, irq_lvl}, 32'h0);
        in_lvl = 2'b01;
        tick(8);
        chk("lvl_irq_masked", {31'd0, irq_lvl}, 32'h0);

        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2);
        chk("w32_mask", rd_w32, 32'hFFFF_FFFF);
        chk("w2_mask", rd_e0, 32'h3);
        chk("w1_mask", rd_w1, 32'h1);
        in_w32 = 32'h8000_0001;
        in_w1  = 1'b1;
        tick(8);
        rd(2'd0);
        chk("w32_data", rd_w32, 32'h8000_0001);
        chk("w1_data", rd_w1, 32'h1);
        rd(2'd3);
        chk("w32_edgecap", rd_w32, 32'h8000_0001);
        chk("w1_edgecap", rd_w1, 32'h1);
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1);
        chk("w1_rsvd", rd_w1, 32'h0);
        chk("w32_rsvd", rd_w32, 32'h0);
        wr(2'd0, 32'hFFFF_FFFF);
        rd(2'd0);
        chk("w1_data_ro", rd_w1, 32'h1);

        chk("w1_irq_high", {31'd0, irq_w1}, 32'h1);
        reset = 1'b1;
        #2;
        chk("async_rst_irq", {31'd0, irq_w1}, 32'h0);
        chk("async_rst_rd", rd_w1, 32'h0);
        chk("async_rst_rd_w32", rd_w32, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd(2'd2); chk("post_rst_mask", rd_w1, 32'h0);
        rd(2'd3); chk("post_rst_edgecap", rd_w1, 32'h0);
        tick(3);
        rd(2'd3); chk("post_rst_edge5", rd_w1, 32'h0);
        rd(2'd3); chk("post_rst_edge6", rd_w1, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
